// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN frame loader.
package cnn_pkg;

    localparam int NUM_PIXELS = 784;
    localparam int ADDR_BIT   = 10;
    localparam int PIX_BIT    = 8;
    localparam int DEC_BIT    = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/image_ram.sv
// Frame buffer: one write port, one registered read port; addresses past the
// end of the frame read back as zero.
module image_ram
    import cnn_pkg::*;
#(
    parameter int DEPTH = NUM_PIXELS,
    parameter int AW    = ADDR_BIT,
    parameter int DW    = PIX_BIT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Same-address read and write in one cycle returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o <= '0;
        end else if (rd_addr_i >= AW'(DEPTH)) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/cnn_frame_loader.sv
// Loads one 28x28 frame from the byte stream, holds the CNN in reset while
// loading, then releases it and captures its decision (or a timeout).
module cnn_frame_loader
    import cnn_pkg::*;
#(
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_BIT    = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic [PIX_BIT-1:0]  rx_data,
    input  logic [ADDR_BIT-1:0] addra,
    output logic [PIX_BIT-1:0]  douta,
    output logic                cnn_rst_n,
    input  logic                cnn_valid,
    input  logic [DEC_BIT-1:0]  cnn_decision,
    output logic [DEC_BIT-1:0]  result,
    output logic                result_valid,
    output logic                timeout,
    output logic                overrun,
    output logic                busy
);

    localparam logic [ADDR_BIT-1:0]    LAST_PIX = ADDR_BIT'(NUM_PIXELS - 1);
    localparam logic [TIMEOUT_BIT-1:0] RST_LAST = TIMEOUT_BIT'(RST_CYCLES - 1);
    localparam logic [TIMEOUT_BIT-1:0] TO_LAST  = TIMEOUT_BIT'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [ADDR_BIT-1:0]     wr_addr_q;
    logic [TIMEOUT_BIT-1:0]  cnt_q;
    logic [DEC_BIT-1:0]      result_q;
    logic                    result_valid_q;
    logic                    timeout_q;
    logic                    overrun_q;

    logic                    ram_we;
    logic [ADDR_BIT-1:0]     ram_waddr;
    logic                    last_pix;
    logic                    hold_done;
    logic                    run_expired;

    assign last_pix    = (wr_addr_q == LAST_PIX);
    assign hold_done   = (cnt_q == RST_LAST);
    assign run_expired = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rx_valid) state_d = ST_LOAD;
            ST_LOAD: if (rx_valid && last_pix) state_d = ST_HOLD;
            ST_HOLD: if (hold_done) state_d = ST_RUN;
            ST_RUN:  if (cnn_valid || run_expired) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnn_rst_n = 1'b0;
        busy      = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = wr_addr_q;
        case (state_q)
            ST_IDLE: begin
                ram_we    = rx_valid;
                ram_waddr = '0;
            end
            ST_LOAD: begin
                busy   = 1'b1;
                ram_we = rx_valid;
            end
            ST_HOLD: busy = 1'b1;
            ST_RUN: begin
                busy      = 1'b1;
                cnn_rst_n = 1'b1;
            end
            default: ;
        endcase
    end

    // cnt_q times the HOLD window, then is reused as the RUN watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q      <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        wr_addr_q <= ADDR_BIT'(1);
                        timeout_q <= 1'b0;
                        overrun_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (rx_valid) begin
                        if (last_pix) begin
                            wr_addr_q <= '0;
                            cnt_q     <= '0;
                        end else begin
                            wr_addr_q <= wr_addr_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_done) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (rx_valid) overrun_q <= 1'b1;
                end
                ST_RUN: begin
                    if (cnn_valid) begin
                        result_q       <= cnn_decision;
                        result_valid_q <= 1'b1;
                    end else if (run_expired) begin
                        timeout_q <= 1'b1;
                    end
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (rx_valid) overrun_q <= 1'b1;
                end
                ST_DONE: begin
                    if (rx_valid) overrun_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;

    image_ram #(
        .DEPTH (NUM_PIXELS),
        .AW    (ADDR_BIT),
        .DW    (PIX_BIT)
    ) u_image_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_data_i (rx_data),
        .rd_addr_i (addra),
        .rd_data_o (douta)
    );

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Scoreboard bench for cnn_frame_loader: frame loads, decision capture,
// timeout, overrun, mid-load reset and read-port boundaries.
module tb_cnn_frame_loader;

    localparam int NPIX     = 784;
    localparam int TO_CYC   = 50;
    localparam int HOLD_CYC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [9:0] addra;
    logic [7:0] douta;
    logic       cnn_rst_n;
    logic       cnn_valid;
    logic [3:0] cnn_decision;
    logic [3:0] result;
    logic       result_valid;
    logic       timeout;
    logic       overrun;
    logic       busy;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    rdq[$];
    logic [3:0] resq[$];
    logic [7:0] modelRam [0:NPIX-1];
    logic       rdReq  = 1'b0;
    logic       rdPipe = 1'b0;
    logic       rvPrev = 1'b0;
    logic [3:0] dec3;
    logic [3:0] dec4;

    cnn_frame_loader #(
        .RST_CYCLES     (HOLD_CYC),
        .TIMEOUT_CYCLES (TO_CYC),
        .TIMEOUT_BIT    (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .addra        (addra),
        .douta        (douta),
        .cnn_rst_n    (cnn_rst_n),
        .cnn_valid    (cnn_valid),
        .cnn_decision (cnn_decision),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] refRead(input int a);
        return (a < NPIX) ? modelRam[a] : 8'h00;
    endfunction

    always @(posedge clk) rdPipe <= rdReq;

    // Monitor: pops the scoreboards whenever the DUT presents read data or a result.
    always @(negedge clk) begin
        rd_exp_t e;
        if (rdPipe) begin
            if (rdq.size() == 0) begin
                checkOutput("read scoreboard underflow", 32'd1, 32'd0);
            end else begin
                e = rdq.pop_front();
                checkOutput($sformatf("douta@%0d", e.addr), douta, e.data);
            end
        end
        if (result_valid === 1'b1) begin
            checkOutput("result_valid width", rvPrev, 1'b0);
            if (resq.size() == 0) begin
                checkOutput("unexpected result_valid", result_valid, 1'b0);
            end else begin
                checkOutput("result value", result, resq.pop_front());
            end
        end
        rvPrev = result_valid;
    end

    task automatic applyStimulus(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic readAddr(input int a);
        rd_exp_t e;
        e.addr = a;
        e.data = refRead(a);
        rdq.push_back(e);
        addra = 10'(a);
        rdReq = 1'b1;
        @(negedge clk);
        rdReq = 1'b0;
    endtask

    task automatic pulseDecision(input logic [3:0] d);
        cnn_valid    = 1'b1;
        cnn_decision = d;
        resq.push_back(d);
        @(negedge clk);
        cnn_valid = 1'b0;
    endtask

    // mode 0: ramp, one byte every 3 cycles; 1: random bytes and gaps; 2: all 0x55.
    task automatic sendFrame(input int mode, input int nbytes);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            case (mode)
                0:       b = 8'(i);
                1:       b = 8'($urandom);
                default: b = 8'h55;
            endcase
            if (i == 0) checkOutput("busy before frame", busy, 1'b0);
            applyStimulus(b);
            modelRam[i] = b;
            if (i == 0) begin
                checkOutput("busy on first byte", busy, 1'b1);
                checkOutput("timeout cleared by first byte", timeout, 1'b0);
                checkOutput("overrun cleared by first byte", overrun, 1'b0);
            end
            if (i != nbytes - 1) begin
                repeat ((mode == 0) ? 2 : $urandom_range(0, 2)) @(negedge clk);
            end
        end
    endtask

    task automatic checkHold();
        int n = 0;
        while (cnn_rst_n === 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("cnn_rst_n low cycles after last byte", n, HOLD_CYC);
    endtask

    task automatic runUntilTimeout();
        int n = 0;
        while (cnn_rst_n === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput("RUN cycles before timeout", n, TO_CYC);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " douta"},        douta,        8'h00);
        checkOutput({tag, " cnn_rst_n"},    cnn_rst_n,    1'b0);
        checkOutput({tag, " result"},       result,       4'h0);
        checkOutput({tag, " result_valid"}, result_valid, 1'b0);
        checkOutput({tag, " timeout"},      timeout,      1'b0);
        checkOutput({tag, " overrun"},      overrun,      1'b0);
        checkOutput({tag, " busy"},         busy,         1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        addra        = '0;
        cnn_valid    = 1'b0;
        cnn_decision = 4'h0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp frame, reads while the CNN runs, then decision 7.
        sendFrame(0, NPIX);
        checkHold();
        readAddr(0);
        readAddr(255);
        readAddr(783);
        readAddr(784);
        readAddr(1023);
        checkOutput("cnn_rst_n in RUN", cnn_rst_n, 1'b1);
        pulseDecision(4'd7);
        checkOutput("cnn_rst_n in DONE", cnn_rst_n, 1'b0);
        checkOutput("busy in DONE", busy, 1'b0);
        @(negedge clk);
        checkOutput("result_valid after pulse", result_valid, 1'b0);
        checkOutput("result held in IDLE", result, 4'd7);
        checkOutput("busy in IDLE", busy, 1'b0);

        // Random frame, CNN never answers.
        sendFrame(1, NPIX);
        checkHold();
        runUntilTimeout();
        checkOutput("timeout set", timeout, 1'b1);
        checkOutput("result kept on timeout", result, 4'd7);
        @(negedge clk);
        checkOutput("timeout sticky in IDLE", timeout, 1'b1);
        for (int k = 0; k < 20; k++) readAddr(int'($urandom_range(0, 1023)));

        // Ramp frame with bytes arriving during RUN.
        sendFrame(0, NPIX);
        checkHold();
        repeat (3) begin
            applyStimulus(8'hAA);
            @(negedge clk);
        end
        checkOutput("overrun set", overrun, 1'b1);
        dec3 = 4'($urandom_range(1, 15));
        pulseDecision(dec3);
        @(negedge clk);
        readAddr(0);
        readAddr(1);
        checkOutput("overrun sticky", overrun, 1'b1);

        // Partial random frame, then asynchronous reset.
        sendFrame(1, 400);
        addra = 10'd700;
        repeat (2) @(negedge clk);
        checkOutput("busy mid-load", busy, 1'b1);
        checkOutput("douta before reset", douta, refRead(700));
        checkOutput("result before reset", result, dec3);
        rst_n = 1'b0;
        #1;
        checkResetValues("async reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        addra = '0;

        // Full 0x55 frame; decision arrives on the watchdog's terminal cycle.
        sendFrame(2, NPIX);
        checkHold();
        repeat (TO_CYC - 1) @(negedge clk);
        checkOutput("still in RUN at terminal cycle", cnn_rst_n, 1'b1);
        dec4 = 4'($urandom_range(1, 15));
        pulseDecision(dec4);
        checkOutput("timeout loses to cnn_valid", timeout, 1'b0);
        for (int a = 0; a < NPIX; a++) readAddr(a);
        readAddr(784);
        readAddr(1023);
        @(negedge clk);
        checkOutput("timeout still clear", timeout, 1'b0);
        checkOutput("read scoreboard drained", rdq.size(), 0);
        checkOutput("result scoreboard drained", resq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cnn_frame_loader.md
Name: cnn_frame_loader

Overview:
- Upstream stage of the CNN top-level.
- Receives one 28x28 8-bit grayscale frame as a byte stream (from the UART receiver) and stores it in an internal 784x8 image RAM.
- Serves that RAM to the CNN through its addra/douta read port, and sequences the CNN by holding it in reset during load, then releasing it.
- Captures the CNN's 4-bit decision and reports it with a one-cycle valid pulse.

Parameters:
- NUM_PIXELS, 784, pixels per frame.
- ADDR_BIT, 10, width of RAM address.
- RST_CYCLES, 4, cycles cnn_rst_n is held low after a frame completes, before release.
- TIMEOUT_CYCLES, 1000000, maximum cycles to wait for the CNN decision after release.
- TIMEOUT_BIT, 20, width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new pixel byte.
- rx_data  in  8  pixel byte, row-major order.
- addra  in  ADDR_BIT  CNN read address.
- douta  out  8  pixel at addra, registered.
- cnn_rst_n  out  1  synchronous active-low reset to the CNN.
- cnn_valid  in  1  CNN final-stage valid (comparator valid).
- cnn_decision  in  4  CNN digit decision.
- result  out  4  latched decision.
- result_valid  out  1  one-cycle pulse: result updated.
- timeout  out  1  sticky: last run ended without cnn_valid.
- overrun  out  1  sticky: byte received while not in LOAD/IDLE.
- busy  out  1  high in LOAD, HOLD, RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, wr_addr=0, douta=0, cnn_rst_n=0, result=0, result_valid=0, timeout=0, overrun=0, busy=0. RAM contents are not reset.
- Read port:
  - douta <= ram[addra] every cycle, giving 1-cycle latency.
  - If addra >= NUM_PIXELS, douta <= 0.
  - Reads are legal in every state.
  - A read and a write to the same address in the same cycle returns old data.
- State machine:
  - IDLE: cnn_rst_n=0. On rx_valid: write byte to ram[0], set wr_addr=1, clear timeout and overrun, go to LOAD.
  - LOAD: cnn_rst_n=0. On each rx_valid: write ram[wr_addr], increment wr_addr. When the write at wr_addr==NUM_PIXELS-1 occurs: clear wr_addr and the counter, go to HOLD. There is no inter-byte timeout; LOAD waits indefinitely.
  - HOLD: cnn_rst_n=0 for exactly RST_CYCLES cycles (counter 0..RST_CYCLES-1), then go to RUN. cnn_rst_n goes high on the first RUN cycle.
  - RUN: cnn_rst_n=1 and the counter increments each cycle.
    - On cnn_valid: result<=cnn_decision, result_valid=1 for the next cycle only, go to DONE.
    - If the counter reaches TIMEOUT_CYCLES-1 without cnn_valid: set timeout=1, leave result unchanged, no result_valid, go to DONE.
    - If cnn_valid and timeout coincide in the same cycle, cnn_valid wins.
  - DONE: drive cnn_rst_n=0 (this re-arms the CNN's internal address counter and its first-decision latch), then go to IDLE next cycle.
- rx_valid outside IDLE/LOAD (HOLD, RUN, DONE): byte is dropped, overrun<=1. The byte is never written to RAM.
- rx_valid in the same cycle as the IDLE entry from DONE: dropped and flagged. A new frame starts only from IDLE.
- busy = (state is LOAD, HOLD or RUN).
- Asynchronous reset mid-LOAD or mid-RUN: all outputs return to reset values immediately. A partial frame is discarded logically; RAM content is stale but harmless, because the next frame overwrites all 784 locations.
- Width rules: wr_addr is ADDR_BIT bits and never exceeds NUM_PIXELS-1. The timeout counter is TIMEOUT_BIT bits and saturates at its terminal value.

Decomposition:
- Shared package cnn_pkg:
  - NUM_PIXELS=784, ADDR_BIT=10, PIX_BIT=8, DEC_BIT=4.
  - State encoding constants for IDLE/LOAD/HOLD/RUN/DONE (3-bit).
- Sub-module image_ram:
  - Simple dual-port memory, one write port and one registered read port, depth NUM_PIXELS, width 8.
  - Inferable as block RAM.
  - Includes the out-of-range read-returns-0 rule.
- The FSM, counters and flags live in cnn_frame_loader.

Test Plan:
- Load ramp frame: 784 bytes with value i mod 256, 1 every 3 cycles. Required response:
  - busy rises on the first byte.
  - After the last byte: cnn_rst_n stays low exactly 4 cycles, then goes high.
  - Reading addra=0, 255, 783 gives douta=0x00, 0xFF, 0x0F one cycle later.
- Decision capture: in RUN, drive cnn_valid=1 with cnn_decision=7 for 1 cycle. Required response:
  - result=7 and result_valid=1 for exactly 1 cycle.
  - cnn_rst_n=0 in DONE; state returns to IDLE; busy=0.
- Timeout: TIMEOUT_CYCLES=50 and cnn_valid never asserted. Required response:
  - timeout=1 on the 50th RUN cycle; result keeps its previous value (7); no result_valid.
  - timeout clears on the first byte of the next frame.
- Overrun: send 3 extra bytes (0xAA) during RUN. Required response:
  - overrun=1 and RAM is unchanged (addra=0 still reads 0x00).
  - Next frame's first byte clears overrun.
- Reset mid-load: assert rst_n low after 400 bytes, release, send a full new frame of 0x55. Required response:
  - Outputs equal reset values immediately on rst_n low.
  - After the new frame, all 784 locations read 0x55 and HOLD/RUN sequence normally.
- Boundary: addra=784 and addra=1023 read 0. A simultaneous cnn_valid and timeout terminal cycle yields result_valid=1 with timeout=0.
